// File: rtl/run_ctrl_pkg.sv
// Shared types and default parameters for the run controller and its bench.
package run_ctrl_pkg;

    localparam int DEF_CW      = 16;
    localparam int DEF_RST_CYC = 2;
    localparam int DEF_TIMEOUT = 4096;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RUN,
        FINISH,
        FAULT
    } run_state_t;

    // States in which the core sits in reset waiting for a host start.
    function automatic logic is_parked(input run_state_t s);
        return (s == IDLE) || (s == FINISH) || (s == FAULT);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/run_ctrl.sv
// Sequences one core execution per host start: hold core in reset, release,
// pulse req, wait for done or timeout, and count RUN cycles.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int CW      = DEF_CW,
    parameter int RST_CYC = DEF_RST_CYC,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          core_done,
    output logic          core_reset,
    output logic          core_req,
    output logic          busy,
    output logic          finished,
    output logic          timed_out,
    output logic [CW-1:0] cycles
);

    localparam int             HW        = $clog2(RST_CYC + 1);
    localparam logic [HW-1:0]  HOLD_LOAD = HW'(RST_CYC);
    localparam logic [CW-1:0]  TO_LAST   = CW'(TIMEOUT - 1);
    localparam bit             TO_EN     = (TIMEOUT != 0);

    run_state_t    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          core_reset_q, core_reset_d;
    logic          core_req_q, core_req_d;
    logic          busy_q, busy_d;
    logic          finished_q, finished_d;
    logic          timed_out_q, timed_out_d;
    logic          cyc_clr;
    logic          cyc_en;

    sat_counter #(
        .W(CW)
    ) u_cycles (
        .clk  (clk),
        .rst_n(reset),
        .clr  (cyc_clr),
        .en   (cyc_en),
        .count(cycles)
    );

    // NOTE: every signal driven here gets a default first, so no latches are inferred.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        finished_d  = finished_q;
        timed_out_d = timed_out_q;
        cyc_clr     = 1'b0;
        cyc_en      = 1'b0;

        unique case (state_q)
            IDLE, FINISH, FAULT: begin
                if (start && !abort) begin
                    state_d     = HOLD;
                    hold_d      = HOLD_LOAD;
                    cyc_clr     = 1'b1;
                    finished_d  = 1'b0;
                    timed_out_d = 1'b0;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - HW'(1);
                    if (hold_q == HW'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (core_done) begin
                    state_d    = FINISH;
                    finished_d = 1'b1;
                end else begin
                    cyc_en = 1'b1;
                    // The counter steps to TIMEOUT on this same edge.
                    if (TO_EN && (cycles == TO_LAST)) begin
                        state_d     = FAULT;
                        timed_out_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        core_reset_d = (state_d != RUN);
        core_req_d   = (state_d == RUN) && (state_q != RUN);
        busy_d       = !is_parked(state_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            core_reset_q <= 1'b1;
            core_req_q   <= 1'b0;
            busy_q       <= 1'b0;
            finished_q   <= 1'b0;
            timed_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            core_reset_q <= core_reset_d;
            core_req_q   <= core_req_d;
            busy_q       <= busy_d;
            finished_q   <= finished_d;
            timed_out_q  <= timed_out_d;
        end
    end

    assign core_reset = core_reset_q;
    assign core_req   = core_req_q;
    assign busy       = busy_q;
    assign finished   = finished_q;
    assign timed_out  = timed_out_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench: two controllers (default and short timeout) share stimulus
// and are compared every cycle against a timeline-based reference model.
module tb_run_ctrl;
    import run_ctrl_pkg::*;

    localparam int CW      = DEF_CW;
    localparam int RC      = DEF_RST_CYC;
    localparam int TO_A    = DEF_TIMEOUT;
    localparam int TO_B    = 64;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct packed {
        logic          rst;
        logic          req;
        logic          busy;
        logic          fin;
        logic          tout;
        logic [CW-1:0] cyc;
    } obs_t;

    localparam obs_t RST_OBS = '{rst: 1'b1, req: 1'b0, busy: 1'b0, fin: 1'b0, tout: 1'b0, cyc: '0};

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic start     = 1'b0;
    logic abort     = 1'b0;
    logic core_done = 1'b0;

    logic          core_reset_a, core_req_a, busy_a, finished_a, timed_out_a;
    logic [CW-1:0] cycles_a;
    logic          core_reset_b, core_req_b, busy_b, finished_b, timed_out_b;
    logic [CW-1:0] cycles_b;

    run_ctrl #(.CW(CW), .RST_CYC(RC), .TIMEOUT(TO_A)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .core_done(core_done),
        .core_reset(core_reset_a), .core_req(core_req_a), .busy(busy_a),
        .finished(finished_a), .timed_out(timed_out_a), .cycles(cycles_a)
    );

    run_ctrl #(.CW(CW), .RST_CYC(RC), .TIMEOUT(TO_B)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .core_done(core_done),
        .core_reset(core_reset_b), .core_req(core_req_b), .busy(busy_b),
        .finished(finished_b), .timed_out(timed_out_b), .cycles(cycles_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    // Reference model: a run is a timeline measured from the accepted start edge.
    bit m_active [2];
    int m_start  [2];
    int m_cnt    [2];
    bit m_fin    [2];
    bit m_tout   [2];
    int m_to     [2];

    obs_t exp_a[$];
    obs_t exp_b[$];

    function automatic obs_t dut_obs(input int i);
        obs_t o;
        if (i == 0) o = {core_reset_a, core_req_a, busy_a, finished_a, timed_out_a, cycles_a};
        else        o = {core_reset_b, core_req_b, busy_b, finished_b, timed_out_b, cycles_b};
        return o;
    endfunction

    function automatic obs_t model_obs(input int i);
        obs_t o;
        int   age;
        bit   in_run;
        age    = edge_n - m_start[i];
        in_run = m_active[i] && (age >= RC);
        o.rst  = !in_run;
        o.req  = m_active[i] && (age == RC);
        o.busy = m_active[i];
        o.fin  = m_fin[i];
        o.tout = m_tout[i];
        o.cyc  = CW'(m_cnt[i]);
        return o;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_start[i]  = 0;
            m_cnt[i]    = 0;
            m_fin[i]    = 1'b0;
            m_tout[i]   = 1'b0;
        end
        m_to[0] = TO_A;
        m_to[1] = TO_B;
    endtask

    task automatic model_edge(input int i, input bit s, input bit a, input bit d);
        int age;
        if (!m_active[i]) begin
            if (s && !a) begin
                m_active[i] = 1'b1;
                m_start[i]  = edge_n;
                m_cnt[i]    = 0;
                m_fin[i]    = 1'b0;
                m_tout[i]   = 1'b0;
            end
        end else begin
            age = edge_n - m_start[i];
            if (a) begin
                m_active[i] = 1'b0;
            end else if (age > RC) begin
                if (d) begin
                    m_active[i] = 1'b0;
                    m_fin[i]    = 1'b1;
                end else begin
                    if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
                    if (m_to[i] != 0 && m_cnt[i] == m_to[i]) begin
                        m_active[i] = 1'b0;
                        m_tout[i]   = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input obs_t act, input obs_t req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s @%0t: got rst=%b req=%b busy=%b fin=%b tout=%b cyc=%0d, required rst=%b req=%b busy=%b fin=%b tout=%b cyc=%0d",
                         name, $time, act.rst, act.req, act.busy, act.fin, act.tout, act.cyc,
                         req.rst, req.req, req.busy, req.fin, req.tout, req.cyc);
        end
    endtask

    // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic cycle(input bit s, input bit a, input bit d);
        @(negedge clk);
        start     = s;
        abort     = a;
        core_done = d;
        @(posedge clk);
        edge_n++;
        model_edge(0, s, a, d);
        model_edge(1, s, a, d);
        exp_a.push_back(model_obs(0));
        exp_b.push_back(model_obs(1));
    endtask

    // done_at / abort_at are RUN-cycle indices; -1 means never.
    task automatic run_job(input int done_at, input int abort_at, input bit ghost, input bit hold_done);
        bit s;
        cycle(1'b1, 1'b0, 1'b0);
        repeat (RC) cycle(1'b0, 1'b0, hold_done);
        for (int k = 0; k < 300; k++) begin
            s = ghost && (k == 3 || k == 7);
            if (k == abort_at) begin
                cycle(s, 1'b1, 1'b0);
                break;
            end
            if (k == done_at) begin
                cycle(s, 1'b0, 1'b1);
                break;
            end
            cycle(s, 1'b0, 1'b0);
        end
    endtask

    task automatic async_reset_mid_run();
        @(negedge clk);
        start     = 1'b0;
        abort     = 1'b0;
        core_done = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_a", dut_obs(0), RST_OBS);
        check("async_reset_b", dut_obs(1), RST_OBS);
        model_reset();
        @(negedge clk);
        check("held_reset_a", dut_obs(0), RST_OBS);
        check("held_reset_b", dut_obs(1), RST_OBS);
        reset = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        obs_t e;
        if (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            check("dut_a", dut_obs(0), e);
        end
        if (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            check("dut_b", dut_obs(1), e);
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        model_reset();
        #1 reset = 1'b0;
        #1;
        check("power_on_reset_a", dut_obs(0), RST_OBS);
        check("power_on_reset_b", dut_obs(1), RST_OBS);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        repeat (2) cycle(1'b1, 1'b1, 1'b0);          // start+abort in IDLE
        cycle(1'b0, 1'b0, 1'b0);

        run_job(130, -1, 1'b0, 1'b0);                // normal run; dut_b times out at 64
        cycle(1'b0, 1'b0, 1'b0);
        run_job(5, -1, 1'b0, 1'b0);                  // restart from FINISH
        run_job(-1, 70, 1'b0, 1'b0);                 // long hang, abort after dut_b FAULT
        cycle(1'b0, 1'b0, 1'b0);
        run_job(-1, 10, 1'b0, 1'b0);                 // abort at RUN cycle 10
        cycle(1'b0, 1'b0, 1'b0);
        run_job(40, -1, 1'b1, 1'b0);                 // ignored starts while busy
        run_job(3, -1, 1'b0, 1'b1);                  // done during HOLD ignored
        run_job(0, -1, 1'b0, 1'b0);                  // done in first RUN cycle
        run_job(0, -1, 1'b0, 1'b0);                  // back-to-back at minimum period
        cycle(1'b1, 1'b0, 1'b0);                     // abort during HOLD
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        cycle(1'b1, 1'b0, 1'b0);                     // reset mid-run at RUN cycle 20
        repeat (RC) cycle(1'b0, 1'b0, 1'b0);
        repeat (20) cycle(1'b0, 1'b0, 1'b0);
        async_reset_mid_run();
        repeat (4) cycle(1'b0, 1'b0, 1'b0);

        for (int c = 0; c < 1500; c++)
            cycle(($urandom % 8) == 0, ($urandom % 32) == 0, ($urandom % 40) == 0);

        cycle(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        n_tests++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0/0", exp_a.size(), exp_b.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run controller that sits directly upstream of the processor top level and sequences one program execution per host request. It holds the core in reset while idle, releases it, pulses `req`, watches the core's `done` output, and counts execution cycles. Runs that never reach `done` end in a timeout, so benches and on-chip hosts get a deterministic result.

## Interface
- `CW`, 16: cycle-counter width.
- `RST_CYC`, 2: cycles `core_reset` stays high after a start; ≥1.
- `TIMEOUT`, 4096: maximum RUN cycles without `core_done`; 0 disables the timeout.

- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: host run request, sampled per cycle.
- `abort` in 1: host cancel.
- `core_done` in 1: `done` from the processor top level.
- `core_reset` out 1: drives the core's `reset`; active-high.
- `core_req` out 1: drives the core's `req`.
- `busy` out 1: high in HOLD and RUN.
- `finished` out 1: level; the last run ended via `core_done`.
- `timed_out` out 1: level; the last run ended via timeout.
- `cycles` out CW: RUN-cycle count of the current or last run.

## Operation
- States: IDLE, HOLD, RUN, FINISH, FAULT.
- All outputs are registered.
- **Reset values:** state=IDLE, `core_reset`=1, `core_req`=0, `busy`=0, `finished`=0, `timed_out`=0, `cycles`=0.
- **IDLE, FINISH, FAULT:**
  - `core_reset`=1; the core's PC is parked. Data memory is unaffected.
  - `start`=1 and `abort`=0 → HOLD. Clears `cycles`, `finished` and `timed_out`, and loads the hold counter with RST_CYC.
  - `start` with `abort`=1: abort wins; the state is unchanged.
- **HOLD:**
  - `core_reset`=1 and `busy`=1; the hold counter decrements each cycle.
  - At 0 → RUN.
  - `core_done` is ignored.
  - `abort` → IDLE.
- **RUN:**
  - `core_reset`=0 and `busy`=1.
  - `core_req`=1 only in the first RUN cycle.
  - Each RUN cycle with `core_done`=0: `cycles`+1, saturating at 2^CW−1.
  - `core_done`=1 → FINISH; `cycles` is not incremented that cycle.
  - `core_done`=0 and `cycles`==TIMEOUT−1 (TIMEOUT≠0) → `cycles` becomes TIMEOUT, then FAULT.
  - `abort` → IDLE. `finished` and `timed_out` stay 0 and `cycles` holds its value.
  - Priority: `abort` > `core_done` > timeout.
- `start` while `busy` is ignored; no queueing.
- Reset asserted mid-run: the block returns to reset values immediately, asynchronously, and `core_reset` rises without waiting for a clock.
- Entering FINISH sets `finished`=1; entering FAULT sets `timed_out`=1. Both hold until the next accepted `start`.

## Timing
- `start` sampled at edge t:
  - HOLD from t+1.
  - `core_reset` high through t+RST_CYC; it is already high in IDLE.
  - RUN and `core_req` at t+RST_CYC+1.
  - `core_reset` low from t+RST_CYC+1.
- `core_done` high at edge u in RUN → `finished`=1, `busy`=0 and `core_reset`=1 at u+1. Latency is 1 cycle.
- `cycles` after a run = number of RUN cycles before `core_done` was first sampled high.
- `abort` at edge a → IDLE, `busy`=0 and `core_reset`=1 at a+1.
- Minimum start-to-start period = RST_CYC+2 cycles.

## Structure
- Package `run_ctrl_pkg`:
  - `run_state_t` enum (IDLE, HOLD, RUN, FINISH, FAULT).
  - Default-parameter constants shared with the bench.
- One sub-module, `sat_counter`: CW-bit counter with synchronous clear, enable and saturation, plus an async active-low reset. It implements `cycles`.
- The hold counter stays inline and uses $clog2(RST_CYC+1) bits.

## Test plan
- **Normal run:** `start` for 1 cycle, core raises `core_done` after 130 RUN cycles. Required: `core_reset` high for 2 cycles, `core_req` 1 pulse, then `finished`=1, `cycles`=130, `busy`=0, `core_reset`=1.
- **Timeout:** TIMEOUT=64, `core_done` held 0. Required: FAULT after 64 RUN cycles, `timed_out`=1, `cycles`=64, `finished`=0.
- **Abort:** `abort` at RUN cycle 10. Required: IDLE next cycle, `core_reset`=1, both flags 0, `cycles`=10.
- **Re-start rules:** `start` pulsed at RUN cycles 3 and 7 is ignored and the run completes normally. A `start` from FINISH clears `finished` and `cycles`.
- **Reset mid-run:** `reset` low at RUN cycle 20, asynchronously. Required: all outputs at reset values before the next edge; after release, remains in IDLE.
- **Edge cases:**
  - `start`+`abort` together in IDLE → stays IDLE.
  - `core_done` already high during HOLD is ignored and the core is still released.
  - `core_done` high in the first RUN cycle → FINISH with `cycles`=0.
